// File: rtl/hypot_pkg.sv
// hypot_pkg: shared FSM states, mode encodings and iteration count for hypot_iter.
package hypot_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic MODE_HYP = 1'b0;
  localparam logic MODE_LEG = 1'b1;
  function automatic int iters(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/hypot_isqrt_step.sv
// hypot_isqrt_step: one restoring square-root digit; tries setting root bit i_bit.
module hypot_isqrt_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]                i_root,
  input  logic [2*WIDTH:0]              i_rem,
  input  logic [$clog2(WIDTH+2)-1:0]    i_bit,
  output logic [WIDTH:0]                o_root,
  output logic [2*WIDTH:0]              o_rem
);
  logic [2*WIDTH+2:0] w_trial;
  logic               w_fit;
  // (r + 2^i)^2 - r^2 = r*2^(i+1) + 4^i, with remainder tracking S - r^2
  always_comb begin
    w_trial = ((2*WIDTH+3)'(i_root) << (int'(i_bit) + 1)) + ((2*WIDTH+3)'(1) << (2 * int'(i_bit)));
    w_fit   = (2*WIDTH+3)'(i_rem) >= w_trial;
    o_root  = w_fit ? i_root | ((WIDTH+1)'(1) << i_bit) : i_root;
    o_rem   = w_fit ? i_rem - w_trial[2*WIDTH:0] : i_rem;
  end
endmodule

// File: rtl/hypot_iter.sv
// hypot_iter: iterative floor(sqrt(a^2 +/- b^2)) with valid/ready handshakes.
module hypot_iter
  import hypot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             exact
);
  localparam int BW = $clog2(WIDTH + 2);
  localparam logic [BW-1:0] NITER = BW'(iters(WIDTH));

  state_t             r_state, w_next;
  logic [2*WIDTH:0]   r_rad, r_rem, w_rem_in, w_rem_nxt, w_s;
  logic [WIDTH:0]     r_root, w_root_nxt, r_result;
  logic [BW-1:0]      r_cnt, w_bit;
  logic [2*WIDTH-1:0] w_aa, w_bb;
  logic               r_exact, w_accept;

  assign w_aa     = (2*WIDTH)'(a) * (2*WIDTH)'(a);
  assign w_bb     = (2*WIDTH)'(b) * (2*WIDTH)'(b);
  assign w_s      = mode == MODE_LEG ? (2*WIDTH+1)'(w_aa >= w_bb ? w_aa - w_bb : w_bb - w_aa)
                                     : (2*WIDTH+1)'(w_aa) + (2*WIDTH+1)'(w_bb);
  assign w_accept = ena && r_state == IDLE && in_valid;
  assign w_bit    = r_cnt - BW'(1);
  // the first step reads the freshly registered radicand as its remainder
  assign w_rem_in = r_cnt == NITER ? r_rad : r_rem;

  hypot_isqrt_step #(.WIDTH(WIDTH)) u_step (
    .i_root(r_root),
    .i_rem (w_rem_in),
    .i_bit (w_bit),
    .o_root(w_root_nxt),
    .o_rem (w_rem_nxt)
  );

  always_comb begin
    w_next = r_state;
    if (ena)
      case (r_state)
        IDLE:    w_next = in_valid ? CALC : IDLE;
        CALC:    w_next = r_cnt == '0 ? DONE : CALC;
        DONE:    w_next = out_ready ? IDLE : DONE;
        default: w_next = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exact  <= 1'b0;
    end else if (ena) begin
      if (w_accept) begin
        r_rad  <= w_s;
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= NITER;
      end else if (r_state == CALC) begin
        if (r_cnt == '0) begin
          r_result <= r_root;
          r_exact  <= r_rem == '0;
        end else begin
          r_root <= w_root_nxt;
          r_rem  <= w_rem_nxt;
          r_cnt  <= r_cnt - BW'(1);
        end
      end
    end

  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign result    = r_result;
  assign exact     = r_exact;
endmodule

// File: tb/tb_hypot_iter.sv
// tb_hypot_iter: directed vector table, handshake/stall/reset sequences and random model checks.
module tb_hypot_iter;
  localparam int W = 8;

  logic         clk = 0, rst_n = 0, ena = 1, in_valid = 0, out_ready = 0, mode = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, exact;
  logic [W:0]   result;
  int           n_cmp = 0, n_bad = 0;

  typedef struct {
    int a;
    int b;
    int m;
    int res;
    int ex;
  } vec_t;

  hypot_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exact(exact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int ia, input int ib, input int im);
    a = W'(ia); b = W'(ib); mode = 1'(im); in_valid = 1;
    tick();
    in_valid = 0;
    a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) chk("timeout", 32'(out_valid), 1);
  endtask

  task automatic release_out();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  function automatic void model(input int ia, input int ib, input int im, output int r, output int ex);
    int s;
    s = im != 0 ? (ia*ia >= ib*ib ? ia*ia - ib*ib : ib*ib - ia*ia) : ia*ia + ib*ib;
    r = 0;
    while ((r+1)*(r+1) <= s) r++;
    ex = (r*r == s) ? 1 : 0;
  endfunction

  initial begin
    vec_t vecs[10];
    int n, n2, r0, er, ee, ia, ib, im;
    vecs = '{'{3,4,0,5,1}, '{255,255,0,360,0}, '{5,3,1,4,1}, '{3,5,1,4,1}, '{7,7,1,0,1},
             '{0,0,0,0,1}, '{6,8,0,10,1}, '{255,0,1,255,1}, '{1,1,0,1,0}, '{0,255,0,255,1}};
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_exact", 32'(exact), 0);
    rst_n = 1;
    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b, vecs[i].m);
      wait_done(n);
      chk($sformatf("vec%0d_lat", i), n, 10);
      chk($sformatf("vec%0d_result", i), 32'(result), vecs[i].res);
      chk($sformatf("vec%0d_exact", i), 32'(exact), vecs[i].ex);
      release_out();
    end
    // backpressure: result holds, new operands are not taken on the release edge
    start(9, 12, 0);
    wait_done(n);
    r0 = 32'(result);
    chk("bp_result", r0, 15);
    a = 8'd1; b = 8'd1; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_stable", 32'(result), r0);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    tick();
    chk("bp_release_idle", 32'(in_ready), 1);
    chk("bp_release_valid", 32'(out_valid), 0);
    in_valid = 0; out_ready = 0;
    tick();
    chk("bp_no_accept", 32'(in_ready), 1);
    chk("idle_hold_result", 32'(result), r0);
    // ena stall mid-CALC
    start(20, 21, 0);
    tick(); tick(); tick();
    ena = 0;
    tick(); tick(); tick();
    chk("stall_frozen", 32'(out_valid), 0);
    ena = 1;
    wait_done(n);
    chk("stall_lat", 6 + n, 13);
    chk("stall_result", 32'(result), 29);
    chk("stall_exact", 32'(exact), 1);
    release_out();
    // asynchronous reset in the middle of CALC
    start(100, 50, 0);
    tick(); tick(); tick(); tick();
    rst_n = 0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    chk("mrst_result", 32'(result), 0);
    tick();
    rst_n = 1;
    start(6, 8, 0);
    wait_done(n);
    chk("mrst_lat", n, 10);
    chk("mrst_result2", 32'(result), 10);
    chk("mrst_exact2", 32'(exact), 1);
    release_out();
    // random operands against the arithmetic model, with random consumer delay
    for (int k = 0; k < 40; k++) begin
      ia = int'($urandom_range(0, 255));
      ib = int'($urandom_range(0, 255));
      im = int'($urandom_range(0, 1));
      if (k % 8 == 0) ib = ia;
      model(ia, ib, im, er, ee);
      start(ia, ib, im);
      wait_done(n);
      chk($sformatf("rnd%0d_lat", k), n, 10);
      n2 = int'($urandom_range(0, 3));
      for (int d = 0; d < n2; d++) tick();
      chk($sformatf("rnd%0d_result a=%0d b=%0d m=%0d", k, ia, ib, im), 32'(result), er);
      chk($sformatf("rnd%0d_exact", k), 32'(exact), ee);
      release_out();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hypot_iter.md
HYPOT_ITER -- requirements
Module: hypot_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 4..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ena, input, 1 bit: clock enable; when low, all state and registers hold.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and mode are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH bits: unsigned side a.
REQ-008 SHALL have port b, input, WIDTH bits: unsigned side b.
REQ-009 SHALL have port mode, input, 1 bit: 0 = hypotenuse floor(sqrt(a²+b²)); 1 = leg floor(sqrt(|a²-b²|)).
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port result, output, WIDTH+1 bits: unsigned integer square root, never truncated.
REQ-013 SHALL have port exact, output, 1 bit: remainder is zero, so the root is exact.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-016 SHALL, on an accept edge (IDLE, ena, in_valid), register the radicand S (2*WIDTH+1 bits) and enter CALC.
- mode 0: S = a*a + b*b.
- mode 1: S = |a*a - b*b|.
REQ-017 SHALL, in CALC, resolve one root bit per enabled edge, MSB first, by digit-by-digit restoring square root, taking exactly WIDTH+1 enabled edges.
REQ-018 SHALL enter DONE after the last root bit; out_valid rises exactly WIDTH+2 enabled edges after the accept edge (10 for WIDTH=8).
REQ-019 SHALL hold result and exact stable in DONE while out_ready is low; no result is ever dropped.
REQ-020 SHALL return to IDLE on the edge where DONE, ena and out_ready are all high; no new operand is accepted on that same edge.
REQ-021 SHALL keep result and exact at their last value outside DONE; consumers qualify them with out_valid.
REQ-022 SHALL, when ena is low, freeze the state, bit counter, partial root, remainder and outputs, even mid-CALC; handshakes are ignored while ena is low.
REQ-023 SHALL ignore a, b and mode outside the accept edge.
REQ-024 SHALL give result 0 and exact 1 when S = 0, including a = b in mode 1.
REQ-025 SHALL not overflow the result at the maximum operands: WIDTH+1 bits always suffice.

Reset
REQ-026 SHALL, while rst_n is low, force:
- state = IDLE, in_ready = 1, out_valid = 0;
- result = 0, exact = 0;
- radicand, remainder, partial root and bit counter = 0.
REQ-027 SHALL abort any CALC or DONE transaction on reset assertion, with no output pulse after release.
REQ-028 SHALL accept operands on the first enabled edge after rst_n deasserts.

Structure
REQ-029 SHALL place in shared package hypot_pkg:
- FSM state typedef (IDLE/CALC/DONE);
- mode constants MODE_HYP = 0 and MODE_LEG = 1;
- function returning the iteration count WIDTH+1.
REQ-030 SHALL place the per-bit square-root step in one combinational sub-module, hypot_isqrt_step, parametrised by WIDTH.
- Inputs: partial root, remainder, bit index.
- Outputs: next root, next remainder.
REQ-031 SHALL keep the FSM, handshake logic and radicand formation in hypot_iter.

Verification (WIDTH=8, ena=1 unless stated)
REQ-032 SHALL verify basic hypotenuse and latency: a=3, b=4, mode=0 -> result=5, exact=1, with out_valid exactly 10 edges after accept.
REQ-033 SHALL verify width growth: a=255, b=255, mode=0 -> result=360 (9 bits), exact=0.
REQ-034 SHALL verify leg mode and abs: a=5, b=3, mode=1 -> result=4, exact=1; a=3, b=5, mode=1 -> result=4, exact=1; a=b=7, mode=1 -> result=0, exact=1.
REQ-035 SHALL verify backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, result is stable, in_ready stays 0; then out_ready=1 -> IDLE on the next edge.
REQ-036 SHALL verify ena stall: drop ena for 3 cycles mid-CALC -> latency grows by exactly 3 and the result is unchanged.
REQ-037 SHALL verify reset mid-operation: assert rst_n low on cycle 4 of CALC -> out_valid=0 and in_ready=1 immediately; a=6, b=8 after release -> result=10.
